// File: rtl/mul_seq_ctrl.sv
// Sequential RV32M multiply controller: splits operand magnitudes into 8-bit limbs,
// accumulates 16 partial products through an external 16-bit multiplier, then fixes sign.
module mul_seq_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    input  logic [31:0] i_mul_p,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, FIX, DONE} state_t;

    state_t      state;
    logic [1:0]  op;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc;
    logic [3:0]  cnt;

    logic        req_sign_a, req_sign_b;
    logic [7:0]  limb_a, limb_b;
    logic [2:0]  limb_sum;
    logic [5:0]  shamt;
    logic [63:0] partial;
    logic [63:0] p;
    logic        unused_bits;

    assign req_sign_a = (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10) ? i_rs1[31] : 1'b0;
    assign req_sign_b = (i_funct3[1:0] == 2'b01) ? i_rs2[31] : 1'b0;

    assign limb_a   = mag_a[{cnt[1:0], 3'b000} +: 8];
    assign limb_b   = mag_b[{cnt[3:2], 3'b000} +: 8];
    assign limb_sum = {1'b0, cnt[1:0]} + {1'b0, cnt[3:2]};
    assign shamt    = {limb_sum, 3'b000};
    // Limbs are at most 0xFF, so only the low 16 product bits can be non-zero.
    assign partial  = {48'b0, i_mul_p[15:0]} << shamt;
    assign p        = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;

    assign o_mul_a     = (state == ACCUM) ? {24'b0, limb_a} : 32'b0;
    assign o_mul_b     = (state == ACCUM) ? {24'b0, limb_b} : 32'b0;
    assign o_req_ready = (state == IDLE);
    assign o_rsp_valid = (state == DONE);
    assign o_busy      = (state != IDLE);
    assign unused_bits = ^{i_mul_p[31:16], i_funct3[2]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            op         <= 2'b00;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            mag_a      <= 32'b0;
            mag_b      <= 32'b0;
            acc        <= 64'b0;
            cnt        <= 4'b0;
            o_rsp_data <= 32'b0;
        end else begin
            case (state)
                IDLE: if (i_req_valid) begin
                    op     <= i_funct3[1:0];
                    sign_a <= req_sign_a;
                    sign_b <= req_sign_b;
                    // Negating 0x80000000 yields 0x80000000, the correct unsigned magnitude.
                    mag_a  <= req_sign_a ? (~i_rs1 + 32'd1) : i_rs1;
                    mag_b  <= req_sign_b ? (~i_rs2 + 32'd1) : i_rs2;
                    acc    <= 64'b0;
                    cnt    <= 4'b0;
                    state  <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + partial;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= FIX;
                end
                FIX: begin
                    o_rsp_data <= (op == 2'b00) ? p[31:0] : p[63:32];
                    state      <= DONE;
                end
                DONE: if (i_rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl; models the external 16-bit signed multiplier.
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic [31:0] mul_a, mul_b, mul_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 16x16 signed multiply, low 32 bits
    assign mul_p = {{16{mul_a[15]}}, mul_a[15:0]} * {{16{mul_b[15]}}, mul_b[15:0]};

    mul_seq_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2),
        .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_p(mul_p),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check latency, optional backpressure, result and handshake.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int n;
        chk({tag, "_rdy"}, req_ready, 1'b1);
        funct3 = f; rs1 = a; rs2 = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 17);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_mula0"}, {mul_a, mul_b}, 64'd0);
        if (hold > 0) begin
            req_valid = 1'b1;
            rs1 = 32'h1234; funct3 = 3'b000;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk({tag, "_bp_vld"}, rsp_valid, 1'b1);
                chk({tag, "_bp_data"}, rsp_data, exp);
                chk({tag, "_bp_rdy"}, req_ready, 1'b0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, {req_ready, rsp_valid, busy}, 3'b100);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        funct3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ctl", {req_ready, rsp_valid, busy}, 3'b100);
        chk("rst_mul", {mul_a, mul_b}, 64'd0);
        chk("rst_data", rsp_data, 32'd0);

        run_op("mul_neg",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("mul_lo_m1",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
        run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mulhu_b2",   3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mulh_m1min", 3'b001, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 0);
        run_op("mulh_min1",  3'b001, 32'h80000000, 32'd1,        32'hFFFFFFFF, 0);
        run_op("mul_2p32",   3'b100, 32'h00010000, 32'h00010000, 32'h00000000, 0);
        run_op("mulh_zero",  3'b001, 32'd0,        32'h80000000, 32'h00000000, 0);
        run_op("mulhu_mid",  3'b011, 32'h00010000, 32'h00030000, 32'h00000003, 0);
        run_op("bp",         3'b000, 32'd1000,     32'd1000,     32'd1000000,  5);

        // Reset in the 8th ACCUM cycle with a request also presented.
        funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd9; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1; req_valid = 1'b1;
        tick();
        chk("mid_rst", {req_ready, busy}, 2'b10);
        tick();
        chk("rst_noacc", {req_ready, busy}, 2'b10);
        rst = 1'b0; req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid) n++;
        end
        chk("no_rsp", n, 0);
        run_op("after_rst", 3'b000, 32'd2, 32'd3, 32'h00000006, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
